axil_req_arbiter: RTL

- Two-requester (parameterisable) round-robin arbiter and sequencer that owns the AXI4-Lite master port driving the s3 register-slave wrapper.
- Accepts simple single-beat read/write commands from internal requesters and runs one complete AXI-Lite transaction at a time: AW+W then B, or AR then R.
- Returns read data and response to the granted requester with a one-cycle done pulse.

---
 rtl/axil_arb_pkg.sv | 16 +
 rtl/axil_req_arbiter_rr_arbiter.sv | 34 +++
 rtl/axil_req_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/axil_arb_pkg.sv
// Shared types and constants for the AXI4-Lite request arbiter.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD      = 3'd3,
    RD_DATA = 3'd4,
    DONE    = 3'd5
  } arb_state_e;

  localparam int RESP_OKAY = 0;
  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/axil_req_arbiter_rr_arbiter.sv
// Combinational round-robin grant: searches from (last_i + 1) mod NUM_REQ upward.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  always_comb begin
    int         cand;
    logic [IDX_W-1:0] cidx;
    logic       found;
    cand      = 0;
    cidx      = '0;
    found     = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_i) + off) % NUM_REQ;
      cidx = IDX_W'(cand);
      if (!found && req_i[cidx]) begin
        found          = 1'b1;
        gnt_o[cidx]    = 1'b1;
        gnt_idx_o      = cidx;
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter and single-transaction AXI4-Lite master sequencer.
// Optional saturating error counter is built only when AXIL_ARB_ERR_CNT_EN is defined.
module axil_req_arbiter
  import axil_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_REQ    = 2
) (
  input  logic                            s3_axi_aclk,
  input  logic                            s3_axi_areset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]              done,
  output logic [DATA_WIDTH-1:0]           done_rdata,
  output logic [RESP_WIDTH-1:0]           done_resp,
  output logic [ADDR_WIDTH-1:0]           m_axi_awaddr,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [DATA_WIDTH-1:0]           m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]         m_axi_wstrb,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [RESP_WIDTH-1:0]           m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready,
  output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
  output logic                            m_axi_arvalid,
  input  logic                            m_axi_arready,
  input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
  input  logic [RESP_WIDTH-1:0]           m_axi_rresp,
  input  logic                            m_axi_rvalid,
  output logic                            m_axi_rready,
  output logic [ERR_CNT_W-1:0]            err_count,
  output logic [2:0]                      dbg_state_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);

  // Handshake rule on every channel: a transfer happens on a rising clock edge
  // where valid and ready are both high; valid never waits for ready and the
  // payload stays constant while valid is high.

  arb_state_e              state_q;
  logic [IDX_W-1:0]        last_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [IDX_W-1:0]        gidx_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    rready_q;
  logic [NUM_REQ-1:0]      done_q;
  logic [DATA_WIDTH-1:0]   done_rdata_q;
  logic [RESP_WIDTH-1:0]   done_resp_q;

  logic [NUM_REQ-1:0]      gnt;
  logic [IDX_W-1:0]        gnt_idx;
  logic                    gnt_any;
  logic                    aw_done;
  logic                    w_done;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i     (req_valid),
    .last_i    (last_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .any_o     (gnt_any)
  );

  // The accept pulse must land in the same cycle the grant is decided.
  assign req_ready = (state_q == IDLE) ? gnt : '0;

  // A channel counts as finished once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || m_axi_awready;
  assign w_done  = !wvalid_q  || m_axi_wready;

  always_ff @(posedge s3_axi_aclk or posedge s3_axi_areset) begin
    if (s3_axi_areset) begin
      state_q      <= IDLE;
      last_q       <= IDX_W'(NUM_REQ - 1);
      gnt_q        <= '0;
      gidx_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      done_q       <= '0;
      done_rdata_q <= '0;
      done_resp_q  <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            gnt_q   <= gnt;
            gidx_q  <= gnt_idx;
            addr_q  <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_q <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
            wstrb_q <= req_wstrb[gnt_idx*STRB_W +: STRB_W];
            if (req_write[gnt_idx]) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD;
            end
          end
        end
        WR: begin
          if (awvalid_q && m_axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi_wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi_bvalid) begin
            bready_q     <= 1'b0;
            done_resp_q  <= m_axi_bresp;
            done_rdata_q <= '0;
            done_q       <= gnt_q;
            state_q      <= DONE;
          end
        end
        RD: begin
          if (m_axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi_rvalid) begin
            rready_q     <= 1'b0;
            done_resp_q  <= m_axi_rresp;
            done_rdata_q <= m_axi_rdata;
            done_q       <= gnt_q;
            state_q      <= DONE;
          end
        end
        DONE: begin
          last_q  <= gidx_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AXIL_ARB_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge s3_axi_aclk or posedge s3_axi_areset) begin
    if (s3_axi_areset) begin
      err_cnt_q <= '0;
    end else if (state_q == DONE && done_resp_q != RESP_WIDTH'(RESP_OKAY) && err_cnt_q != '1) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign done          = done_q;
  assign done_rdata    = done_rdata_q;
  assign done_resp     = done_resp_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign dbg_state_o   = state_q;

endmodule
